// File: rtl/image_pkg.sv
// Shared BMP constants and reader state encoding for the image read stream.
package image_pkg;

  localparam int unsigned BMP_HEADER_NUM = 54;
  localparam logic [7:0]  BMP_SIG0       = 8'd66;
  localparam logic [7:0]  BMP_SIG1       = 8'd77;
  localparam int unsigned OFS_WIDTH      = 18;
  localparam int unsigned OFS_HEIGHT     = 22;
  localparam int unsigned OFS_BPP        = 28;
  localparam logic [15:0] BMP_BPP        = 16'd24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_OUT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bmp_header_parser.sv
// Captures signature, width, height and bpp from the streamed BMP header and
// flags whether the header describes a frame this reader can handle.
module bmp_header_parser
  import image_pkg::*;
#(
  parameter int unsigned HDR_NUM    = BMP_HEADER_NUM,
  parameter int unsigned MAX_WIDTH  = 768,
  parameter int unsigned MAX_HEIGHT = 512
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        clr,
  input  logic        rd,
  input  logic [31:0] addr,
  input  logic [7:0]  rdata,
  output logic [31:0] width,
  output logic [31:0] height,
  output logic        last_c,
  output logic        ok_c
);

  logic        vld_q;
  logic [31:0] idx_q;
  logic [7:0]  sig0_q;
  logic [7:0]  sig1_q;
  logic [15:0] bpp_q;

  // Read data trails the strobe by one cycle, so the address is delayed with it.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      vld_q  <= 1'b0;
      idx_q  <= '0;
      sig0_q <= '0;
      sig1_q <= '0;
      bpp_q  <= '0;
      width  <= '0;
      height <= '0;
    end else begin
      vld_q <= rd;
      idx_q <= addr;
      if (clr) begin
        sig0_q <= '0;
        sig1_q <= '0;
        bpp_q  <= '0;
        width  <= '0;
        height <= '0;
      end else if (vld_q) begin
        case (idx_q)
          32'd0:                  sig0_q        <= rdata;
          32'd1:                  sig1_q        <= rdata;
          32'(OFS_WIDTH):         width[7:0]    <= rdata;
          32'(OFS_WIDTH + 1):     width[15:8]   <= rdata;
          32'(OFS_WIDTH + 2):     width[23:16]  <= rdata;
          32'(OFS_WIDTH + 3):     width[31:24]  <= rdata;
          32'(OFS_HEIGHT):        height[7:0]   <= rdata;
          32'(OFS_HEIGHT + 1):    height[15:8]  <= rdata;
          32'(OFS_HEIGHT + 2):    height[23:16] <= rdata;
          32'(OFS_HEIGHT + 3):    height[31:24] <= rdata;
          32'(OFS_BPP):           bpp_q[7:0]    <= rdata;
          32'(OFS_BPP + 1):       bpp_q[15:8]   <= rdata;
          default: ;
        endcase
      end
    end
  end

  assign last_c = vld_q && (idx_q == 32'(HDR_NUM - 1));

  assign ok_c = (sig0_q == BMP_SIG0) && (sig1_q == BMP_SIG1) && (bpp_q == BMP_BPP) &&
                (width != 32'd0) && (height != 32'd0) &&
                (width <= 32'(MAX_WIDTH)) && (height <= 32'(MAX_HEIGHT));

endmodule

// File: rtl/image_read_stream.sv
// Reads a 24-bit BMP from a byte buffer and streams pixels top-down with a
// valid/ready handshake. Define IMAGE_READ_PADDING_EN for 4-byte padded rows.
module image_read_stream
  import image_pkg::*;
#(
  parameter int unsigned MAX_WIDTH      = 768,
  parameter int unsigned MAX_HEIGHT     = 512,
  parameter int unsigned BMP_HEADER_NUM = image_pkg::BMP_HEADER_NUM
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] width,
  output logic [31:0] height,
  output logic [10:0] row,
  output logic [10:0] col,
  output logic [7:0]  DATA_R,
  output logic [7:0]  DATA_G,
  output logic [7:0]  DATA_B,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        hdr_err
);

  state_t      state_q, state_n;
  logic [1:0]  ph_q, ph_n;
  logic [7:0]  b_q, b_n, g_q, g_n;
  logic        mem_rd_n, pix_valid_n, busy_n, frame_done_n, hdr_err_n;
  logic [31:0] mem_addr_n, stride_c;
  logic [10:0] row_n, col_n, nrow_c, ncol_c;
  logic [7:0]  data_r_n, data_g_n, data_b_n;
  logic        hdr_last_c, hdr_ok_c, col_wrap_c, last_px_c;

  bmp_header_parser #(
    .HDR_NUM    (BMP_HEADER_NUM),
    .MAX_WIDTH  (MAX_WIDTH),
    .MAX_HEIGHT (MAX_HEIGHT)
  ) u_hdr (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .clr    (start && (state_q == ST_IDLE)),
    .rd     (mem_rd && (state_q == ST_HDR)),
    .addr   (mem_addr),
    .rdata  (mem_rdata),
    .width  (width),
    .height (height),
    .last_c (hdr_last_c),
    .ok_c   (hdr_ok_c)
  );

`ifdef IMAGE_READ_PADDING_EN
  assign stride_c = (32'd3 * width + 32'd3) & ~32'd3;
`else
  assign stride_c = 32'd3 * width;
`endif

  // BMP rows are stored bottom-up; output row 0 is the last stored row.
  function automatic logic [31:0] pix_addr(input logic [31:0] stride, input logic [31:0] h,
                                           input logic [10:0] r, input logic [10:0] c);
    return 32'(BMP_HEADER_NUM) + stride * (h - 32'd1 - 32'(r)) + 32'd3 * 32'(c);
  endfunction

  assign col_wrap_c = (32'(col) == width - 32'd1);
  assign last_px_c  = col_wrap_c && (32'(row) == height - 32'd1);
  assign nrow_c     = col_wrap_c ? row + 11'd1 : row;
  assign ncol_c     = col_wrap_c ? 11'd0 : col + 11'd1;

  always_comb begin
    state_n      = state_q;
    ph_n         = ph_q;
    b_n          = b_q;
    g_n          = g_q;
    mem_rd_n     = 1'b0;
    mem_addr_n   = mem_addr;
    row_n        = row;
    col_n        = col;
    data_r_n     = DATA_R;
    data_g_n     = DATA_G;
    data_b_n     = DATA_B;
    pix_valid_n  = pix_valid;
    frame_done_n = 1'b0;
    hdr_err_n    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_n    = ST_HDR;
          mem_rd_n   = 1'b1;
          mem_addr_n = 32'd0;
          row_n      = 11'd0;
          col_n      = 11'd0;
        end
      end
      ST_HDR: begin
        if (mem_rd && (mem_addr != 32'(BMP_HEADER_NUM - 1))) begin
          mem_rd_n   = 1'b1;
          mem_addr_n = mem_addr + 32'd1;
        end
        if (hdr_last_c) begin
          if (!hdr_ok_c) begin
            hdr_err_n = 1'b1;
            state_n   = ST_IDLE;
          end else begin
            state_n    = ST_FETCH;
            mem_rd_n   = 1'b1;
            mem_addr_n = pix_addr(stride_c, height, 11'd0, 11'd0);
            ph_n       = 2'd0;
          end
        end
      end
      // Phases: issue B, issue G, issue R, then R lands and the pixel is presented.
      ST_FETCH: begin
        case (ph_q)
          2'd0: begin
            mem_rd_n   = 1'b1;
            mem_addr_n = mem_addr + 32'd1;
            ph_n       = 2'd1;
          end
          2'd1: begin
            mem_rd_n   = 1'b1;
            mem_addr_n = mem_addr + 32'd1;
            b_n        = mem_rdata;
            ph_n       = 2'd2;
          end
          2'd2: begin
            g_n  = mem_rdata;
            ph_n = 2'd3;
          end
          default: begin
            data_b_n    = b_q;
            data_g_n    = g_q;
            data_r_n    = mem_rdata;
            pix_valid_n = 1'b1;
            state_n     = ST_OUT;
          end
        endcase
      end
      ST_OUT: begin
        if (pix_ready) begin
          pix_valid_n = 1'b0;
          if (last_px_c) begin
            state_n      = ST_DONE;
            frame_done_n = 1'b1;
          end else begin
            state_n    = ST_FETCH;
            row_n      = nrow_c;
            col_n      = ncol_c;
            mem_rd_n   = 1'b1;
            mem_addr_n = pix_addr(stride_c, height, nrow_c, ncol_c);
            ph_n       = 2'd0;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      ph_q       <= '0;
      b_q        <= '0;
      g_q        <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      row        <= '0;
      col        <= '0;
      DATA_R     <= '0;
      DATA_G     <= '0;
      DATA_B     <= '0;
      pix_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      hdr_err    <= 1'b0;
    end else begin
      state_q    <= state_n;
      ph_q       <= ph_n;
      b_q        <= b_n;
      g_q        <= g_n;
      mem_rd     <= mem_rd_n;
      mem_addr   <= mem_addr_n;
      row        <= row_n;
      col        <= col_n;
      DATA_R     <= data_r_n;
      DATA_G     <= data_g_n;
      DATA_B     <= data_b_n;
      pix_valid  <= pix_valid_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
      hdr_err    <= hdr_err_n;
    end
  end

endmodule

// File: tb/tb_image_read_stream.sv
// Directed bench for image_read_stream: byte-buffer model, transfer/read logs,
// and hand-derived expectations for pixel order, addresses and status pulses.
module tb_image_read_stream;

`ifdef IMAGE_READ_PADDING_EN
  localparam int STR5 = 16;
`else
  localparam int STR5 = 15;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET, start, pix_ready;
  logic        mem_rd, pix_valid, busy, frame_done, hdr_err;
  logic [31:0] mem_addr, width, height;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  DATA_R, DATA_G, DATA_B;
  logic [10:0] row, col;

  always #5 HCLK = ~HCLK;

  image_read_stream dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .width(width), .height(height), .row(row), .col(col),
    .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .busy(busy), .frame_done(frame_done), .hdr_err(hdr_err)
  );

  logic [7:0] mem [0:4095];
  always @(posedge HCLK) if (mem_rd) mem_rdata <= mem[mem_addr[11:0]];

  int          cyc = 0;
  int          rd_a[$], rd_c[$], rise_c[$];
  logic [42:0] px[$];
  int          n_fd, n_he;
  bit          v_prev, v_seen, he_prev, busy_after_he;

  always @(negedge HCLK) begin
    cyc++;
    if (mem_rd) begin rd_a.push_back(int'(mem_addr)); rd_c.push_back(cyc); end
    if (pix_valid && !v_prev) rise_c.push_back(cyc);
    if (pix_valid) v_seen = 1'b1;
    v_prev = pix_valid;
    if (pix_valid && pix_ready) px.push_back({row, col, DATA_B, DATA_G, DATA_R});
    if (frame_done) n_fd++;
    if (he_prev) busy_after_he = busy;
    he_prev = hdr_err;
    if (hdr_err) n_he++;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_a.delete(); rd_c.delete(); rise_c.delete(); px.delete();
    n_fd = 0; n_he = 0; v_seen = 1'b0; busy_after_he = 1'b1;
  endtask

  function automatic int base_of(int w, int h, int s, int i);
    return 54 + s * (h - 1 - i / w) + 3 * (i % w);
  endfunction

  function automatic logic [42:0] exp_px(int w, int h, int s, int i);
    int b = base_of(w, h, s, i);
    return {11'(i / w), 11'(i % w), mem[b], mem[b + 1], mem[b + 2]};
  endfunction

  task automatic build_img(input int w, input int h, input logic [7:0] b0, input int bpp);
    for (int i = 0; i < 4096; i++) mem[i] = (i < 54) ? 8'h00 : 8'((i * 7 + 3) ^ (i >> 3));
    mem[0] = b0; mem[1] = 8'd77;
    for (int k = 0; k < 4; k++) begin
      mem[18 + k] = 8'(w >> (8 * k));
      mem[22 + k] = 8'(h >> (8 * k));
    end
    mem[28] = 8'(bpp); mem[29] = 8'(bpp >> 8);
  endtask

  // Runs one start..idle sequence; optional stall, extra start, or mid-frame reset.
  task automatic run_frame(input int w, input int h, input int s,
                           input int stall_idx, input int start_idx, input int rst_idx);
    int          stall_left = 10;
    bit          done = 1'b0, extra = 1'b0;
    logic [42:0] snap = '0;
    clear_logs();
    @(posedge HCLK); #1 start = 1'b1;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(posedge HCLK); #1;
      start = 1'b0;
      pix_ready = 1'b1;
      if (rst_idx >= 0 && px.size() == rst_idx && mem_rd) begin
        HRESET = 1'b1; #1;
        check("reset_clears_outputs",
              192'({mem_addr, width, height, row, col, DATA_R, DATA_G, DATA_B,
                    pix_valid, busy, frame_done, hdr_err, mem_rd}), 192'(0));
        @(posedge HCLK); #1 HRESET = 1'b0;
        repeat (3) @(posedge HCLK); #1;
        check("reset_waits_idle", 192'({busy, mem_rd, pix_valid}), 192'(0));
        return;
      end
      if (start_idx >= 0 && px.size() == start_idx && pix_valid && !extra) begin
        start = 1'b1; extra = 1'b1;
      end
      if (stall_idx >= 0 && px.size() == stall_idx && pix_valid && stall_left > 0) begin
        pix_ready = 1'b0;
        if (stall_left == 10) begin
          snap = {row, col, DATA_B, DATA_G, DATA_R};
          check("stall_pixel_value", 192'(snap), 192'(exp_px(w, h, s, stall_idx)));
        end else begin
          check("stall_hold", 192'({row, col, DATA_B, DATA_G, DATA_R}), 192'(snap));
        end
        check("stall_no_rd", 192'(mem_rd), 192'(0));
        stall_left--;
      end
      if (!busy) done = 1'b1;
    end
    if (!done) check("frame_timeout", 192'(0), 192'(1));
    pix_ready = 1'b0;
    repeat (2) @(posedge HCLK); #1;
  endtask

  task automatic check_frame(input int w, input int h, input int s, input int npix);
    check("pixel_count", 192'(px.size()), 192'(npix));
    check("read_count", 192'(rd_a.size()), 192'(54 + 3 * npix));
    check("frame_done_count", 192'(n_fd), 192'(1));
    check("hdr_err_count", 192'(n_he), 192'(0));
    check("width", 192'(width), 192'(w));
    check("height", 192'(height), 192'(h));
    if (rd_a.size() >= 54) begin
      check("hdr_first_addr", 192'(rd_a[0]), 192'(0));
      check("hdr_last_addr", 192'(rd_a[53]), 192'(53));
    end
    for (int i = 0; i < npix && i < px.size() && 56 + 3 * i < rd_a.size(); i++) begin
      int b = base_of(w, h, s, i);
      int k = 54 + 3 * i;
      check("pixel", 192'(px[i]), 192'(exp_px(w, h, s, i)));
      check("pixel_addr", 192'({32'(rd_a[k]), 32'(rd_a[k + 1]), 32'(rd_a[k + 2])}),
            192'({32'(b), 32'(b + 1), 32'(b + 2)}));
      if (i < rise_c.size()) check("valid_latency", 192'(rise_c[i] - rd_c[k]), 192'(4));
    end
    check("idle_after_frame", 192'({busy, mem_rd, pix_valid}), 192'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    HRESET = 1'b1; start = 1'b0; pix_ready = 1'b0;
    clear_logs();
    repeat (3) @(posedge HCLK); #1;
    check("reset_state_held",
          192'({mem_addr, width, height, row, col, DATA_R, DATA_G, DATA_B,
                pix_valid, busy, frame_done, hdr_err, mem_rd}), 192'(0));
    HRESET = 1'b0;
    repeat (2) @(posedge HCLK); #1;
    check("idle_after_release", 192'({busy, mem_rd, pix_valid, row, col}), 192'(0));

    // 4x2 frame, ready always high
    build_img(4, 2, 8'd66, 24);
    run_frame(4, 2, 12, -1, -1, -1);
    check_frame(4, 2, 12, 8);

    // bad signature
    build_img(4, 2, 8'h41, 24);
    run_frame(4, 2, 12, -1, -1, -1);
    check("bad_sig_hdr_err", 192'(n_he), 192'(1));
    check("bad_sig_no_valid", 192'(v_seen), 192'(0));
    check("bad_sig_busy_next", 192'(busy_after_he), 192'(0));
    check("bad_sig_reads", 192'(rd_a.size()), 192'(54));
    check("bad_sig_no_done", 192'(n_fd), 192'(0));

    // width above MAX_WIDTH
    build_img(769, 1, 8'd66, 24);
    run_frame(769, 1, 2307, -1, -1, -1);
    check("wide_hdr_err", 192'(n_he), 192'(1));
    check("wide_no_valid", 192'(v_seen), 192'(0));

    // stall on pixel (0,2)
    build_img(4, 2, 8'd66, 24);
    run_frame(4, 2, 12, 2, -1, -1);
    check_frame(4, 2, 12, 8);

    // reset during fetch of pixel (1,1), then a clean frame
    build_img(4, 2, 8'd66, 24);
    run_frame(4, 2, 12, -1, -1, 5);
    run_frame(4, 2, 12, -1, -1, -1);
    check_frame(4, 2, 12, 8);

    // 5x2 stride, with a start pulse during OUT that must be ignored
    build_img(5, 2, 8'd66, 24);
    run_frame(5, 2, STR5, -1, 2, -1);
    check_frame(5, 2, STR5, 10);
    check("row0_base_5wide", 192'(base_of(5, 2, STR5, 0)), 192'(54 + STR5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
